csi_pkt_handler_mc: RTL
=======================

// Module: csi_pkt_handler_mc
// PURPOSE
//   Parametrised successor of the single-channel packet-handler FSM. Sits after lane merge and header
//   ECC check; takes merged byte beats plus decoded 24-bit packet headers and emits pixel payload
//   beats with byte enables. Tracks frame state per virtual channel (VC), filters VCs, trims the
//   final beat to the header word count, counts lines and flags protocol errors.
// PARAMETERS
//   LANES    2      bytes per beat (1..4); DATA_W = 8*LANES
//   VC_MASK  4'hF   bit v=1 -> VC v is forwarded; packets on masked-off VCs are consumed silently
//   LINE_W   12     width of per-frame line counter
// PORTS
//   clk           in   1        rising-edge clock
//   reset         in   1        asynchronous, active-low reset
//   data_stream   in   DATA_W   payload bytes, byte 0 in [7:0]
//   ph_stream     in   24       header: [5:0] DT, [7:6] VC, [23:8] WC (long) / frame-line no. (short)
//   ph_select     in   1        beat carries a header on ph_stream, not payload
//   valid_stream  in   1        beat valid; no beat is consumed when low
//   ecc_error     in   1        uncorrectable ECC on this header; qualified by ph_select
//   out_stream    out  DATA_W   payload out (registered)
//   out_valid     out  1        out_stream valid
//   out_be        out  LANES    byte enables; all ones except on the last beat
//   out_last      out  1        last beat of long packet
//   out_vc        out  2        VC of current payload
//   out_dt        out  6        DT of current payload
//   frame_active  out  4        per-VC: high from FS to FE
//   frame_valid   out  1        high while the payload of a forwarded long packet is streaming
//   line_count    out  LINE_W   completed long packets since FS on out_vc; saturates at all-ones
//   err_ecc       out  1        1-cycle pulse: header dropped for ECC
//   err_trunc     out  1        1-cycle pulse: header arrived before payload WC was exhausted
//   err_seq       out  1        1-cycle pulse: FE without FS, or FS while already active
// BEHAVIOUR
//   Reset: all outputs 0, state IDLE, counters 0. Latency: 1 clk, input beat -> registered outputs.
//   Header accept: valid_stream & ph_select. Data beat: valid_stream & ~ph_select.
//   States: IDLE (awaiting header), PAYLOAD (forwarding), SKIP (consuming masked VC), DROP (post-ECC).
//   Header with ecc_error=1: ignore contents, pulse err_ecc, go DROP; stay in DROP, discarding data
//     beats, until next accepted header, which is processed normally.
//   Short DTs: 0x00 FS, 0x01 FE; 0x02-0x0F accepted and ignored. Short packets never leave IDLE.
//     FS on VC v: frame_active[v]<=1, line_count<=0; if already active -> err_seq, restart frame.
//     FE on VC v: frame_active[v]<=0; if not active -> err_seq, no other effect.
//     FS/FE on masked VC: no effect.
//   Long DT (>=0x10): rem<=WC. WC==0 -> stay IDLE, no beats, line_count+1. Otherwise PAYLOAD if
//     VC_MASK[vc], else SKIP. Each data beat: if rem<=LANES, last beat: out_be=(1<<rem)-1,
//     out_last=1, line_count+1 (saturating, only if forwarded), next IDLE; else rem<=rem-LANES.
//   SKIP: identical count, no outputs. Data beats in IDLE are discarded.
//   Header accepted in PAYLOAD/SKIP: err_trunc pulse, no out_last for truncated packet, new header
//     processed in the same cycle. frame_valid falls the cycle after out_last or truncation.
//   Long packet on VC with frame_active=0 still forwarded; line_count unchanged.
//   Reset asserted mid-packet: immediate return to reset values; no out_last emitted.
// TESTING
//   1 LANES=2: FS vc0, long DT 0x2A WC=6, 3 beats -> 3 out_valid, be 2'b11 x3, out_last on 3rd, line_count=1
//   2 LANES=2 WC=5: beats 3 -> last be 2'b01, out_last=1; FE vc0 -> frame_active[0]=0
//   3 Long hdr WC=8, 2 beats then new hdr -> err_trunc pulse, no out_last, line_count unchanged
//   4 Hdr with ecc_error=1, 4 data beats, then FS vc1 -> err_ecc pulse, no out_valid, frame_active[1]=1
//   5 VC_MASK=4'h1: long pkt vc2 WC=4 -> no out_valid; next vc0 pkt forwarded normally
//   6 FE vc3 w/o FS -> err_seq; FS vc0 twice -> err_seq, line_count=0; reset low mid-payload -> all 0

Source files
------------

// File: rtl/csi_pkt_handler_mc_if.sv
// Beat-level bus between lane merge / header ECC and the packet handler:
// merged input beats with decoded headers, and the registered payload output.
interface csi_pkt_handler_mc_if #(
    parameter int LANES = 2
);
    localparam int DATA_W = 8 * LANES;

    logic [DATA_W-1:0] data_stream;
    logic [23:0]       ph_stream;
    logic              ph_select;
    logic              valid_stream;
    logic              ecc_error;

    logic [DATA_W-1:0] out_stream;
    logic              out_valid;
    logic [LANES-1:0]  out_be;
    logic              out_last;
    logic [1:0]        out_vc;
    logic [5:0]        out_dt;

    modport master (
        output data_stream, ph_stream, ph_select, valid_stream, ecc_error,
        input  out_stream, out_valid, out_be, out_last, out_vc, out_dt
    );

    modport slave (
        input  data_stream, ph_stream, ph_select, valid_stream, ecc_error,
        output out_stream, out_valid, out_be, out_last, out_vc, out_dt
    );
endinterface

// File: rtl/csi_pkt_handler_mc.sv
// Multi-VC CSI packet handler: per-VC frame tracking, VC filtering, final-beat
// trimming to the header word count, line counting and protocol error pulses.
module csi_pkt_handler_mc #(
    parameter int         LANES   = 2,
    parameter logic [3:0] VC_MASK = 4'hF,
    parameter int         LINE_W  = 12
) (
    input  logic                   clk,
    input  logic                   reset,
    csi_pkt_handler_mc_if.slave    bus,
    output logic [3:0]             frame_active,
    output logic                   frame_valid,
    output logic [LINE_W-1:0]      line_count,
    output logic                   err_ecc,
    output logic                   err_trunc,
    output logic                   err_seq
);
    localparam int          DATA_W  = 8 * LANES;
    localparam logic [15:0] LANES_W = 16'(LANES);
    localparam logic [5:0]  DT_FS   = 6'h00;
    localparam logic [5:0]  DT_FE   = 6'h01;
    localparam logic [5:0]  DT_LONG = 6'h10;

    typedef enum logic [1:0] {IDLE, PAYLOAD, SKIP, DROP} state_t;

    function automatic logic [LANES-1:0] be_mask(input logic [15:0] r);
        logic [LANES-1:0] m;
        for (int i = 0; i < LANES; i++) m[i] = (16'(i) < r);
        return m;
    endfunction

    function automatic logic [LINE_W-1:0] sat_inc(input logic [LINE_W-1:0] c);
        return (c == '1) ? c : c + 1'b1;
    endfunction

    state_t                   state_q, state_n;
    logic [15:0]              rem_q, rem_n;
    logic [DATA_W-1:0]        data_p1, data_n;
    logic                     vld_p1, vld_n;
    logic [LANES-1:0]         be_p1, be_n;
    logic                     last_p1, last_n;
    logic [1:0]               vc_p1, vc_n;
    logic [5:0]               dt_p1, dt_n;
    logic                     fv_p1, fv_n;
    logic [3:0]               fa_p1, fa_n;
    logic [3:0][LINE_W-1:0]   lc_p1, lc_n;
    logic                     ecc_p1, ecc_n;
    logic                     trunc_p1, trunc_n;
    logic                     seq_p1, seq_n;

    logic        hdr_acc, dat_acc;
    logic [5:0]  h_dt;
    logic [1:0]  h_vc;
    logic [15:0] h_wc;

    assign hdr_acc = bus.valid_stream & bus.ph_select;
    assign dat_acc = bus.valid_stream & ~bus.ph_select;
    assign h_dt    = bus.ph_stream[5:0];
    assign h_vc    = bus.ph_stream[7:6];
    assign h_wc    = bus.ph_stream[23:8];

    always_comb begin
        state_n = state_q;
        rem_n   = rem_q;
        data_n  = data_p1;
        vld_n   = 1'b0;
        be_n    = '0;
        last_n  = 1'b0;
        vc_n    = vc_p1;
        dt_n    = dt_p1;
        fa_n    = fa_p1;
        lc_n    = lc_p1;
        ecc_n   = 1'b0;
        trunc_n = 1'b0;
        seq_n   = 1'b0;

        if (hdr_acc) begin
            // A header always wins; an unfinished packet is abandoned without out_last.
            trunc_n = (state_q == PAYLOAD) || (state_q == SKIP);
            if (bus.ecc_error) begin
                ecc_n   = 1'b1;
                state_n = DROP;
            end else if (h_dt < DT_LONG) begin
                state_n = IDLE;
                if (VC_MASK[h_vc] && h_dt == DT_FS) begin
                    seq_n       = fa_p1[h_vc];
                    fa_n[h_vc]  = 1'b1;
                    lc_n[h_vc]  = '0;
                end else if (VC_MASK[h_vc] && h_dt == DT_FE) begin
                    seq_n       = ~fa_p1[h_vc];
                    fa_n[h_vc]  = 1'b0;
                end
            end else begin
                rem_n = h_wc;
                if (h_wc == 16'd0) begin
                    state_n = IDLE;
                    if (VC_MASK[h_vc] && fa_p1[h_vc]) lc_n[h_vc] = sat_inc(lc_p1[h_vc]);
                end else if (VC_MASK[h_vc]) begin
                    state_n = PAYLOAD;
                    vc_n    = h_vc;
                    dt_n    = h_dt;
                end else begin
                    state_n = SKIP;
                end
            end
        end else if (dat_acc && (state_q == PAYLOAD || state_q == SKIP)) begin
            if (state_q == PAYLOAD) begin
                vld_n  = 1'b1;
                data_n = bus.data_stream;
                be_n   = '1;
            end
            if (rem_q <= LANES_W) begin
                state_n = IDLE;
                rem_n   = '0;
                if (state_q == PAYLOAD) begin
                    be_n   = be_mask(rem_q);
                    last_n = 1'b1;
                    if (fa_p1[vc_p1]) lc_n[vc_p1] = sat_inc(lc_p1[vc_p1]);
                end
            end else begin
                rem_n = rem_q - LANES_W;
            end
        end

        // Held through the out_last cycle so it drops one cycle later.
        fv_n = (state_n == PAYLOAD) || last_n;
    end

    // Stage p1: registered outputs, one clock after the input beat.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            rem_q    <= '0;
            data_p1  <= '0;
            vld_p1   <= 1'b0;
            be_p1    <= '0;
            last_p1  <= 1'b0;
            vc_p1    <= '0;
            dt_p1    <= '0;
            fv_p1    <= 1'b0;
            fa_p1    <= '0;
            lc_p1    <= '0;
            ecc_p1   <= 1'b0;
            trunc_p1 <= 1'b0;
            seq_p1   <= 1'b0;
        end else begin
            state_q  <= state_n;
            rem_q    <= rem_n;
            data_p1  <= data_n;
            vld_p1   <= vld_n;
            be_p1    <= be_n;
            last_p1  <= last_n;
            vc_p1    <= vc_n;
            dt_p1    <= dt_n;
            fv_p1    <= fv_n;
            fa_p1    <= fa_n;
            lc_p1    <= lc_n;
            ecc_p1   <= ecc_n;
            trunc_p1 <= trunc_n;
            seq_p1   <= seq_n;
        end
    end

    assign bus.out_stream = data_p1;
    assign bus.out_valid  = vld_p1;
    assign bus.out_be     = be_p1;
    assign bus.out_last   = last_p1;
    assign bus.out_vc     = vc_p1;
    assign bus.out_dt     = dt_p1;
    assign frame_active   = fa_p1;
    assign frame_valid    = fv_p1;
    assign line_count     = lc_p1[vc_p1];
    assign err_ecc        = ecc_p1;
    assign err_trunc      = trunc_p1;
    assign err_seq        = seq_p1;
endmodule
